// File: rtl/imem_ctrl.sv
// ---------------------------------------------------------------------------
// imem_ctrl
// Sequencer and arbiter for the single-port, word-organised instruction
// memory. Normally it passes CPU fetch reads through to the memory with a
// one-cycle read latency. On ld_start it switches to program-load mode:
// bytes from a loader stream (typically a UART receiver) are assembled
// little-endian into 32-bit words and written sequentially from word 0,
// with the CPU held off until LOAD_WORDS words have been written.
//
// Parameters:
//   ADDR_W      byte-address width into instruction memory (word index is
//               ADDR_W-2 bits)
//   LOAD_WORDS  number of words written per load (<= 2**(ADDR_W-2))
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   fetch_req/fetch_addr     fetch read request and byte address
//   fetch_ready              request accepted this cycle
//   fetch_valid/fetch_inst   read result, one cycle after acceptance
//   ld_start                 begin a program load
//   ld_valid/ld_byte/ld_ready  loader byte stream handshake
//   cpu_hold                 stalls the core for the whole load
//   ld_checksum              running sum of loaded words (optional)
//   mem_we/mem_addr/mem_wdata/mem_rdata  instruction memory port
//
// Build option:
//   IMEM_CTRL_CHECKSUM_EN    when defined, ld_checksum accumulates the
//                            modulo-2^32 sum of every word written during a
//                            load; when undefined it is tied to 0.
// ---------------------------------------------------------------------------
module imem_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int LOAD_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_inst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic [31:0]       ld_checksum,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WI = ADDR_W - 2;
  localparam logic [WI-1:0] LAST_IDX = WI'(LOAD_WORDS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_byte_cnt;
  logic [WI-1:0] r_word_idx;
  logic [31:0]   r_word;
  logic          r_fetch_valid;
  logic [31:0]   r_inst_hold;

  logic          w_fetch_ready;
  logic          w_fetch_accept;
  logic          w_byte_take;
  logic          w_unused_addr;

  // Only the word-index bits of the fetch address reach the memory.
  assign w_unused_addr = ^{fetch_addr[31:ADDR_W], fetch_addr[1:0]};

  // ld_start pre-empts a fetch in the same cycle so the load never races a
  // read whose result would land while the core is already held.
  assign w_fetch_ready  = (r_state == S_RUN) && !rst && !ld_start;
  assign w_fetch_accept = fetch_req && w_fetch_ready;
  assign w_byte_take    = (r_state == S_LOAD) && ld_valid;

  assign fetch_ready = w_fetch_ready;
  assign fetch_valid = r_fetch_valid;
  assign ld_ready    = (r_state == S_LOAD);
  assign cpu_hold    = (r_state != S_RUN);
  assign mem_we      = (r_state == S_WRITE);
  assign mem_wdata   = r_word;
  assign mem_addr    = (r_state == S_RUN) ? fetch_addr[ADDR_W-1:2] : r_word_idx;

  // The memory output register already provides the one-cycle read latency,
  // so the valid cycle forwards mem_rdata directly; r_inst_hold keeps that
  // word afterwards so fetch_inst stays stable between valid pulses.
  assign fetch_inst = r_fetch_valid ? mem_rdata : r_inst_hold;

  // Main sequencer: RUN passes fetches through, LOAD collects four bytes,
  // WRITE commits the assembled word and advances or finishes the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_byte_cnt    <= 2'd0;
      r_word_idx    <= '0;
      r_word        <= 32'd0;
      r_fetch_valid <= 1'b0;
      r_inst_hold   <= 32'd0;
    end else begin
      r_fetch_valid <= w_fetch_accept;
      if (r_fetch_valid) begin
        r_inst_hold <= mem_rdata;
      end

      case (r_state)
        S_RUN: begin
          if (ld_start) begin
            r_state    <= S_LOAD;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
            r_word     <= 32'd0;
          end
        end

        S_LOAD: begin
          if (w_byte_take) begin
            // Byte 0 of each word lands in bits [7:0] (little-endian).
            r_word[{r_byte_cnt, 3'b000} +: 8] <= ld_byte;
            r_byte_cnt                        <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (r_word_idx == LAST_IDX) begin
            r_word_idx <= '0;
            r_state    <= S_RUN;
          end else begin
            r_word_idx <= r_word_idx + 1'b1;
            r_state    <= S_LOAD;
          end
        end

        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

`ifdef IMEM_CTRL_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Sum of every word committed in the current load; restarts on ld_start
  // and keeps its final value once the load is over.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= 32'd0;
    end else if ((r_state == S_RUN) && ld_start) begin
      r_checksum <= 32'd0;
    end else if (r_state == S_WRITE) begin
      r_checksum <= r_checksum + r_word;
    end
  end

  assign ld_checksum = r_checksum;
`else
  assign ld_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_ctrl
// Self-checking bench for imem_ctrl (ADDR_W=8, LOAD_WORDS=4). A behavioural
// synchronous-read memory sits on the memory port. Each table row is one
// clock cycle: inputs are driven after the falling edge and the outputs are
// compared 1 ns later, so the expected values describe that same cycle.
// ---------------------------------------------------------------------------
module tb_imem_ctrl;

  localparam int ADDR_W     = 8;
  localparam int LOAD_WORDS = 4;

`ifdef IMEM_CTRL_CHECKSUM_EN
  localparam logic [31:0] EXP_SUM = 32'd10;
`else
  localparam logic [31:0] EXP_SUM = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_inst;
  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              cpu_hold;
  logic [31:0]       ld_checksum;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              tbPreWe;
  logic [5:0]        tbPreAddr;
  logic [31:0]       tbPreData;
  logic [31:0]       mem [0:63];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        start;
    logic        lv;
    logic [7:0]  lb;
    logic        fr;
    logic        fv;
    logic [31:0] fi;
    logic        lr;
    logic        hold;
    logic        we;
    logic        chkA;
    logic [5:0]  ea;
    logic [31:0] ew;
  } vec_t;

  vec_t tblA[$];
  vec_t tblB[$];

  imem_ctrl #(.ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .ld_checksum(ld_checksum),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory with a bench-side preload port.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
    end else if (tbPreWe) begin
      mem[tbPreAddr] <= tbPreData;
    end
    mem_rdata <= mem[mem_addr];
  end

  function automatic vec_t mkVec(
    input logic req, input logic [31:0] addr, input logic start,
    input logic lv, input logic [7:0] lb,
    input logic fr, input logic fv, input logic [31:0] fi,
    input logic lr, input logic hold, input logic we,
    input logic chkA, input logic [5:0] ea, input logic [31:0] ew);
    vec_t v;
    v.req = req; v.addr = addr; v.start = start; v.lv = lv; v.lb = lb;
    v.fr = fr; v.fv = fv; v.fi = fi; v.lr = lr; v.hold = hold; v.we = we;
    v.chkA = chkA; v.ea = ea; v.ew = ew;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input int row, input vec_t v);
    @(negedge clk);
    fetch_req  = v.req;
    fetch_addr = v.addr;
    ld_start   = v.start;
    ld_valid   = v.lv;
    ld_byte    = v.lb;
    #1;
    checkOutput({tag, ".fetch_ready"}, row, {31'd0, fetch_ready}, {31'd0, v.fr});
    checkOutput({tag, ".fetch_valid"}, row, {31'd0, fetch_valid}, {31'd0, v.fv});
    checkOutput({tag, ".fetch_inst"},  row, fetch_inst, v.fi);
    checkOutput({tag, ".ld_ready"},    row, {31'd0, ld_ready}, {31'd0, v.lr});
    checkOutput({tag, ".cpu_hold"},    row, {31'd0, cpu_hold}, {31'd0, v.hold});
    checkOutput({tag, ".mem_we"},      row, {31'd0, mem_we}, {31'd0, v.we});
    if (v.chkA) begin
      checkOutput({tag, ".mem_addr"}, row, {26'd0, mem_addr}, {26'd0, v.ea});
    end
    if (v.we) begin
      checkOutput({tag, ".mem_wdata"}, row, mem_wdata, v.ew);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = 32'd0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'd0;
    tbPreWe = 1'b0; tbPreAddr = 6'd0; tbPreData = 32'd0;

    // Fetch stream, fetch completing into a load, ld_start vs fetch_req,
    // first load word, then two partial bytes of word 1.
    //                  req  addr   st  lv  byte   fr  fv  inst          lr  hd  we  chkA ea  wdata
    tblA.push_back(mkVec(1, 32'h00, 0, 0, 8'h00, 1, 0, 32'h0,        0, 0, 0, 1, 0, 0));
    tblA.push_back(mkVec(1, 32'h04, 0, 0, 8'h00, 1, 1, 32'h11111111, 0, 0, 0, 1, 1, 0));
    tblA.push_back(mkVec(1, 32'h08, 0, 0, 8'h00, 1, 1, 32'h22222222, 0, 0, 0, 1, 2, 0));
    tblA.push_back(mkVec(0, 32'h00, 0, 0, 8'h00, 1, 1, 32'h33333333, 0, 0, 0, 0, 0, 0));
    tblA.push_back(mkVec(1, 32'h0C, 0, 0, 8'h00, 1, 0, 32'h33333333, 0, 0, 0, 1, 3, 0));
    tblA.push_back(mkVec(1, 32'h04, 1, 0, 8'h00, 0, 1, 32'h44444444, 0, 0, 0, 0, 0, 0));
    tblA.push_back(mkVec(0, 32'h00, 0, 1, 8'hEF, 0, 0, 32'h44444444, 1, 1, 0, 0, 0, 0));
    tblA.push_back(mkVec(0, 32'h00, 1, 1, 8'h00, 0, 0, 32'h44444444, 1, 1, 0, 0, 0, 0));
    tblA.push_back(mkVec(0, 32'h00, 0, 1, 8'h40, 0, 0, 32'h44444444, 1, 1, 0, 0, 0, 0));
    tblA.push_back(mkVec(0, 32'h00, 0, 1, 8'h07, 0, 0, 32'h44444444, 1, 1, 0, 0, 0, 0));
    tblA.push_back(mkVec(0, 32'h00, 0, 0, 8'h00, 0, 0, 32'h44444444, 0, 1, 1, 1, 0, 32'h074000EF));
    tblA.push_back(mkVec(0, 32'h00, 1, 1, 8'hAB, 0, 0, 32'h44444444, 1, 1, 0, 0, 0, 0));
    tblA.push_back(mkVec(0, 32'h00, 0, 1, 8'hCD, 0, 0, 32'h44444444, 1, 1, 0, 0, 0, 0));

    // Full four-word load of 1,2,3,4 with a toggling ld_valid on word 1,
    // followed by a fetch of the last word written.
    tblB.push_back(mkVec(0, 32'h00, 1, 0, 8'h00, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    tblB.push_back(mkVec(0, 32'h00, 0, 1, 8'h01, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tblB.push_back(mkVec(0, 32'h00, 0, 1, 8'h00, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0));
    tblB.push_back(mkVec(0, 32'h00, 0, 0, 8'h00, 0, 0, 32'h0, 0, 1, 1, 1, 0, 32'd1));
    tblB.push_back(mkVec(0, 32'h00, 0, 1, 8'h02, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tblB.push_back(mkVec(0, 32'h00, 0, 0, 8'hFF, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0));
      tblB.push_back(mkVec(0, 32'h00, 0, 1, 8'h00, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0));
    end
    tblB.push_back(mkVec(0, 32'h00, 0, 0, 8'h00, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'd2));
    for (int w = 3; w <= 4; w++) begin
      tblB.push_back(mkVec(0, 32'h00, 0, 1, 8'(w), 0, 0, 32'h0, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
        tblB.push_back(mkVec(0, 32'h00, 0, 1, 8'h00, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0));
      tblB.push_back(mkVec(0, 32'h00, 0, 0, 8'h00, 0, 0, 32'h0, 0, 1, 1, 1, 6'(w-1), 32'(w)));
    end
    tblB.push_back(mkVec(1, 32'h0C, 0, 0, 8'h00, 1, 0, 32'h0, 0, 0, 0, 1, 3, 0));
    tblB.push_back(mkVec(0, 32'h00, 0, 0, 8'h00, 1, 1, 32'd4, 0, 0, 0, 0, 0, 0));

    // Preload words 0..3 while reset is held.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tbPreWe   = 1'b1;
      tbPreAddr = 6'(i);
      tbPreData = {4{8'(8'h11 * (i + 1))}};
      #1;
      checkOutput("rst.fetch_ready", i, {31'd0, fetch_ready}, 32'd0);
    end
    @(negedge clk);
    tbPreWe = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst.fetch_valid", 0, {31'd0, fetch_valid}, 32'd0);
    checkOutput("rst.fetch_inst",  0, fetch_inst, 32'd0);
    checkOutput("rst.ld_ready",    0, {31'd0, ld_ready}, 32'd0);
    checkOutput("rst.cpu_hold",    0, {31'd0, cpu_hold}, 32'd0);
    checkOutput("rst.mem_we",      0, {31'd0, mem_we}, 32'd0);
    checkOutput("rst.ld_checksum", 0, ld_checksum, 32'd0);
    rst = 1'b0;

    foreach (tblA[i]) applyStimulus("A", i, tblA[i]);

    // Reset in the middle of word 1: load abandoned, word 0 kept.
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b0; ld_start = 1'b0; fetch_req = 1'b0;
    #1;
    checkOutput("midrst.fetch_ready_in_rst", 0, {31'd0, fetch_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst.cpu_hold",    0, {31'd0, cpu_hold}, 32'd0);
    checkOutput("midrst.ld_ready",    0, {31'd0, ld_ready}, 32'd0);
    checkOutput("midrst.mem_we",      0, {31'd0, mem_we}, 32'd0);
    checkOutput("midrst.ld_checksum", 0, ld_checksum, 32'd0);
    checkOutput("midrst.fetch_inst",  0, fetch_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst.fetch_ready_run", 0, {31'd0, fetch_ready}, 32'd1);
    checkOutput("midrst.mem0_kept",     0, mem[0], 32'h074000EF);
    checkOutput("midrst.mem1_unwritten", 0, mem[1], 32'h22222222);

    foreach (tblB[i]) applyStimulus("B", i, tblB[i]);

    checkOutput("load.ld_checksum", 0, ld_checksum, EXP_SUM);
    @(negedge clk);
    #1;
    checkOutput("load.ld_checksum_held", 0, ld_checksum, EXP_SUM);
    checkOutput("load.mem3", 0, mem[3], 32'd4);
    checkOutput("load.mem1", 0, mem[1], 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
